// File: rtl/uart_upload_pkg.sv
// Shared types and constants for the periodic UART status frame uploader.
package uart_upload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } upload_state_e;

  localparam int CHK_SUM = 0;
  localparam int CHK_XOR = 1;

  localparam logic [7:0] HDR0_DEFAULT = 8'hAF;
  localparam logic [7:0] HDR1_DEFAULT = 8'hFA;

  function automatic logic [7:0] chk_step(input int mode, input logic [7:0] acc,
                                          input logic [7:0] b);
    logic [7:0] r;
    r = (mode == CHK_XOR) ? (acc ^ b) : (acc + b);
    return r;
  endfunction

endpackage

// File: rtl/upload_period_timer.sv
// Free-running upload interval counter; tick marks the last count of each period.
module upload_period_timer #(
  parameter int PERIOD_CYCLES = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic period_en,
  output logic tick
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!period_en || (count_q == LAST)) count_d = '0;
    else                                 count_d = count_q + 1'b1;
  end

  assign tick = period_en && (count_q == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule

// File: rtl/uart_frame_uploader.sv
// Frames a payload snapshot as HDR0,HDR1,LEN,payload,CHK and streams it to uart_tx.
module uart_frame_uploader
  import uart_upload_pkg::*;
#(
  parameter int         PERIOD_CYCLES = 50_000_000,
  parameter int         PAYLOAD_LEN   = 6,
  parameter logic [7:0] HDR0          = HDR0_DEFAULT,
  parameter logic [7:0] HDR1          = HDR1_DEFAULT,
  parameter int         CHK_MODE      = 0,
  parameter int         ACK_TIMEOUT   = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [8*PAYLOAD_LEN-1:0] payload_data,
  input  logic                     upload_trig,
  input  logic                     period_en,
  input  logic                     tx_busy,
  output logic                     send_en,
  output logic [7:0]               send_data,
  output logic                     frame_active,
  output logic                     frame_done,
  output logic [7:0]               overrun_cnt,
  output logic                     ack_err
);

  localparam int NBYTES = PAYLOAD_LEN + 4;
  localparam int IW     = $clog2(NBYTES);
  localparam int TW     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NBYTES - 1);
  localparam logic [IW-1:0] LAST_PL_IDX = IW'(PAYLOAD_LEN + 2);
  localparam logic [IW-1:0] LEN_IDX     = IW'(2);

  upload_state_e            state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [7:0]               acc_q, acc_d;
  logic [8*PAYLOAD_LEN-1:0] buf_q, buf_d;
  logic [TW-1:0]            to_q, to_d;
  logic                     send_en_q, send_en_d;
  logic [7:0]               send_data_q, send_data_d;
  logic                     frame_active_q, frame_active_d;
  logic                     frame_done_q, frame_done_d;
  logic [7:0]               overrun_q, overrun_d;
  logic                     ack_err_q, ack_err_d;
  logic                     tick, req;

  upload_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .period_en (period_en),
    .tick      (tick)
  );

  // The last index carries the finished checksum rather than a stored byte.
  function automatic logic [7:0] frame_byte(input logic [IW-1:0] idx,
                                            input logic [8*PAYLOAD_LEN-1:0] pl,
                                            input logic [7:0] chk);
    int i;
    logic [7:0] b;
    i = int'(idx);
    if (i == 0)                     b = HDR0;
    else if (i == 1)                b = HDR1;
    else if (i == 2)                b = 8'(PAYLOAD_LEN);
    else if (i <= PAYLOAD_LEN + 2)  b = pl[8*(i-3) +: 8];
    else                            b = chk;
    return b;
  endfunction

  assign req = tick | upload_trig;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    buf_d          = buf_q;
    to_d           = to_q;
    send_en_d      = 1'b0;
    send_data_d    = send_data_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    overrun_d      = overrun_q;
    ack_err_d      = ack_err_q;

    if (req && frame_active_q && (overrun_q != 8'hFF)) overrun_d = overrun_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d        = ST_LOAD;
          buf_d          = payload_data;
          idx_d          = '0;
          acc_d          = '0;
          frame_active_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!tx_busy) begin
          state_d     = ST_SEND;
          send_en_d   = 1'b1;
          send_data_d = frame_byte(idx_q, buf_q, acc_q);
        end
      end
      ST_SEND: begin
        // send_data_q already holds byte[idx_q]; headers and CHK itself are excluded.
        if ((idx_q >= LEN_IDX) && (idx_q <= LAST_PL_IDX))
          acc_d = chk_step(CHK_MODE, acc_q, send_data_q);
        to_d    = TW'(ACK_TIMEOUT - 1);
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_IDLE;
        end else if (to_q == '0) begin
          ack_err_d = 1'b1;
          state_d   = ST_WAIT_IDLE;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            idx_d       = idx_q + 1'b1;
            state_d     = ST_SEND;
            send_en_d   = 1'b1;
            send_data_d = frame_byte(idx_d, buf_q, acc_q);
          end
        end
      end
      ST_DONE: begin
        frame_active_d = 1'b0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      buf_q          <= '0;
      to_q           <= '0;
      send_en_q      <= 1'b0;
      send_data_q    <= '0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= '0;
      ack_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      buf_q          <= buf_d;
      to_q           <= to_d;
      send_en_q      <= send_en_d;
      send_data_q    <= send_data_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
      ack_err_q      <= ack_err_d;
    end
  end

  assign send_en      = send_en_q;
  assign send_data    = send_data_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign overrun_cnt  = overrun_q;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_uart_frame_uploader.sv
// Directed + randomized bench: sum-mode and XOR-mode uploaders share one UART model.
module tb_uart_frame_uploader;

  localparam int PL       = 2;
  localparam int PERIOD   = 200;
  localparam int NB       = PL + 4;
  localparam int BUSY_LEN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] payload = 16'h0;
  logic        trig = 1'b0;
  logic        pen = 1'b0;
  logic        tx_busy;
  logic        se0, se1, fa0, fa1, fd0, fd1, ae0, ae1;
  logic [7:0]  sd0, sd1, ov0, ov1;

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  bit   tx_dead = 1'b0;
  int   done_cnt = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  uart_frame_uploader #(.PERIOD_CYCLES(PERIOD), .PAYLOAD_LEN(PL), .CHK_MODE(0)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .payload_data(payload), .upload_trig(trig),
    .period_en(pen), .tx_busy(tx_busy), .send_en(se0), .send_data(sd0),
    .frame_active(fa0), .frame_done(fd0), .overrun_cnt(ov0), .ack_err(ae0));

  uart_frame_uploader #(.PERIOD_CYCLES(PERIOD), .PAYLOAD_LEN(PL), .CHK_MODE(1)) u_dut_x (
    .sys_clk(clk), .sys_rst_n(rst_n), .payload_data(payload), .upload_trig(trig),
    .period_en(pen), .tx_busy(tx_busy), .send_en(se1), .send_data(sd1),
    .frame_active(fa1), .frame_done(fd1), .overrun_cnt(ov1), .ack_err(ae1));

  // UART transmitter model: busy for BUSY_LEN cycles after each strobe, or never when dead.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (se0 && !tx_dead)   busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (se0) q0.push_back(sd0);
    if (se1) q1.push_back(sd1);
    if (fd0) done_cnt++;
  end

  function automatic logic [7:0] model_byte(input int k, input logic [15:0] pl, input int mode);
    logic [7:0] f[NB];
    logic [7:0] c;
    f[0] = 8'hAF;
    f[1] = 8'hFA;
    f[2] = 8'(PL);
    for (int j = 0; j < PL; j++) f[3+j] = pl[8*j +: 8];
    c = 8'h00;
    for (int j = 2; j < NB - 1; j++) c = (mode == 1) ? (c ^ f[j]) : 8'(c + f[j]);
    f[NB-1] = c;
    return f[k];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step(1);
    trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != start), 1);
  endtask

  task automatic wait_bytes(input string tag, input int nb, input int budget);
    int n;
    n = 0;
    while (q0.size() < nb && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_bytes_seen"}, 32'(q0.size() >= nb), 1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] pl);
    check({tag, "_len_sum"}, q0.size(), NB);
    check({tag, "_len_xor"}, q1.size(), NB);
    for (int k = 0; k < NB; k++) begin
      if (k < q0.size()) check($sformatf("%s_sum_b%0d", tag, k), q0[k], model_byte(k, pl, 0));
      if (k < q1.size()) check($sformatf("%s_xor_b%0d", tag, k), q1[k], model_byte(k, pl, 1));
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_send_en"},  se0, 0);
    check({tag, "_send_data"}, sd0, 0);
    check({tag, "_frame_active"}, fa0, 0);
    check({tag, "_frame_done"}, fd0, 0);
    check({tag, "_overrun"}, ov0, 0);
    check({tag, "_ack_err"}, ae0, 0);
    check({tag, "_xor_outs"}, {se1, sd1, fa1, fd1, ov1, ae1}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pl;
    int d0;

    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Periodic frame from the interval counter.
    payload = 16'h3412;
    d0 = done_cnt;
    pen = 1'b1;
    wait_done("periodic", 400);
    pen = 1'b0;
    step(5);
    check("periodic_done_once", done_cnt - d0, 1);
    check_frame("periodic", 16'h3412);

    // Triggered frames with random payloads; payload changes mid-frame must not leak in.
    for (int r = 0; r < 4; r++) begin
      pl = 16'($urandom);
      payload = pl;
      pulse_trig();
      check($sformatf("trig%0d_active_t1", r), fa0, 1);
      check($sformatf("trig%0d_send_en_t1", r), se0, 0);
      step(1);
      check($sformatf("trig%0d_send_en_t2", r), se0, 1);
      check($sformatf("trig%0d_data_t2", r), sd0, 8'hAF);
      payload = 16'($urandom);
      wait_done($sformatf("trig%0d", r), 300);
      check_frame($sformatf("trig%0d", r), pl);
      step(3);
    end

    // Trigger while a frame is in flight is dropped and counted.
    pl = 16'($urandom);
    payload = pl;
    pulse_trig();
    wait_bytes("overrun", 2, 100);
    check("overrun_active", fa0, 1);
    pulse_trig();
    wait_done("overrun", 300);
    check("overrun_cnt_sum", ov0, 1);
    check("overrun_cnt_xor", ov1, 1);
    check_frame("overrun", pl);
    step(40);
    check("overrun_no_extra_frame", q0.size(), 0);

    // Trigger coincident with a tick: one frame, no overrun.
    do_reset();
    pl = 16'($urandom);
    payload = pl;
    d0 = done_cnt;
    pen = 1'b1;
    step(PERIOD - 1);
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    pen = 1'b0;
    wait_done("simul", 300);
    step(30);
    check("simul_one_frame", done_cnt - d0, 1);
    check("simul_overrun", ov0, 0);
    check_frame("simul", pl);

    // Transmitter never acknowledges: error is sticky, frame still completes.
    do_reset();
    tx_dead = 1'b1;
    pl = 16'($urandom);
    payload = pl;
    pulse_trig();
    step(1);
    check("timeout_first_send", se0, 1);
    step(16);
    check("timeout_ack_err_before", ae0, 0);
    step(1);
    check("timeout_ack_err_after", ae0, 1);
    wait_done("timeout", 400);
    check("timeout_ack_err_xor", ae1, 1);
    check_frame("timeout", pl);
    tx_dead = 1'b0;

    // Reset in the middle of a frame clears everything, including the sticky error.
    pl = 16'($urandom);
    payload = pl;
    pulse_trig();
    wait_bytes("midrst", 3, 200);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step(2);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    step(15);
    pl = 16'($urandom);
    payload = pl;
    pulse_trig();
    wait_done("after_rst", 300);
    check_frame("after_rst", pl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
